// File: rtl/bram_frame_reader_pkg.sv
// Shared constants for the sample-frame writer/reader pair.
// Frame layout (halfword indices), FIFO depth, reader FSM states.
package bram_frame_reader_pkg;

    localparam int FRAME_HW_DEFAULT = 40;

    localparam int HW_TS_S  = 0;
    localparam int HW_TS_NS = 2;
    localparam int HW_PCH   = 4;
    localparam int HW_TCH   = 20;
    localparam int HW_PT100 = 36;

    localparam int FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } rd_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bram_frame_reader_fifo.sv
// hw_fifo: 4-entry 16-bit FIFO, one push and a two-entry pop per cycle.
// Ports: clk, rst (sync, high), push/wdata, pop2, rd0/rd1 (two oldest), count.
module hw_fifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        push,
    input  logic [15:0] wdata,
    input  logic        pop2,
    output logic [15:0] rd0,
    output logic [15:0] rd1,
    output logic [2:0]  count
);

    logic [15:0] mem [0:3];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;

    assign rd0 = mem[rd_ptr];
    assign rd1 = mem[rd_ptr + 2'd1];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop2) begin
                rd_ptr <= rd_ptr + 2'd2;
            end
            count <= count + {2'b00, push} - (pop2 ? 3'd2 : 3'd0);
        end
    end

endmodule

// File: rtl/bram_frame_reader.sv
// Reads one sample frame out of the frame BRAM on a frame_irq rising edge
// and streams it as FRAME_HW/2 32-bit AXI-Stream beats.
// Ports: aclk/areset (sync, high); frame_irq trigger; bram_addr/bram_en/
// bram_dout read port; m_axis_* stream; busy, frame_cnt, drop_cnt status.
import bram_frame_reader_pkg::*;

module bram_frame_reader #(
    parameter int FRAME_HW  = FRAME_HW_DEFAULT,
    parameter int BASE_ADDR = 0,
    parameter int ADDR_W    = 12
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              frame_irq,
    output logic [ADDR_W-1:0] bram_addr,
    output logic              bram_en,
    input  logic [15:0]       bram_dout,
    output logic [31:0]       m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              m_axis_tlast,
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       drop_cnt
);

    localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(FRAME_HW - 1);
    localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(FRAME_HW / 2 - 1);

    rd_state_e         state;
    rd_state_e         state_nxt;
    logic              irq_q;
    logic              trig;
    logic              rd_valid;
    logic              issue;
    logic [ADDR_W-1:0] issue_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic [ADDR_W-1:0] beat_idx;
    logic [2:0]        fifo_count;
    logic [15:0]       fifo_hw0;
    logic [15:0]       fifo_hw1;
    logic              out_free;
    logic              pop;
    logic              last_acc;
    logic [3:0]        pending;
    logic              room;

    assign trig     = frame_irq & ~irq_q;
    assign out_free = ~m_axis_tvalid | m_axis_tready;
    assign pop      = out_free & (fifo_count >= 3'd2);
    assign last_acc = m_axis_tvalid & m_axis_tready & m_axis_tlast;

    // Halfwords that will occupy the FIFO once every outstanding read has
    // landed: current entries, the word on bram_dout, the read in the BRAM,
    // less this cycle's pop. A new read is allowed only if it still fits.
    assign pending = {1'b0, fifo_count}
                   + {3'b000, rd_valid}
                   + {3'b000, bram_en}
                   - (pop ? 4'd2 : 4'd0);
    assign room    = pending < 4'(FIFO_DEPTH);

    hw_fifo u_fifo (
        .clk   (aclk),
        .rst   (areset),
        .push  (rd_valid),
        .wdata (bram_dout),
        .pop2  (pop),
        .rd0   (fifo_hw0),
        .rd1   (fifo_hw1),
        .count (fifo_count)
    );

    always_ff @(posedge aclk) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:  if (trig) state_nxt = ST_READ;
            ST_READ:  if (issue && rd_idx == LAST_IDX) state_nxt = ST_DRAIN;
            ST_DRAIN: if (last_acc) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Halfword 0 is read straight from IDLE so the pipeline starts on the
    // trigger edge itself.
    always_comb begin
        issue     = 1'b0;
        issue_idx = rd_idx;
        unique case (state)
            ST_IDLE: begin
                issue     = trig;
                issue_idx = '0;
            end
            ST_READ:  issue = room;
            ST_DRAIN: issue = 1'b0;
            default:  issue = 1'b0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            irq_q         <= 1'b0;
            bram_en       <= 1'b0;
            bram_addr     <= '0;
            rd_valid      <= 1'b0;
            rd_idx        <= '0;
            beat_idx      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            busy          <= 1'b0;
            frame_cnt     <= '0;
            drop_cnt      <= '0;
        end else begin
            irq_q    <= frame_irq;
            bram_en  <= issue;
            rd_valid <= bram_en;
            if (issue) begin
                bram_addr <= BASE + issue_idx;
                rd_idx    <= issue_idx + ADDR_W'(1);
            end
            if (state == ST_IDLE && trig) begin
                busy     <= 1'b1;
                beat_idx <= '0;
            end
            if (trig && state != ST_IDLE) begin
                drop_cnt <= sat_inc16(drop_cnt);
            end
            if (pop) begin
                m_axis_tdata  <= {fifo_hw0, fifo_hw1};
                m_axis_tvalid <= 1'b1;
                m_axis_tlast  <= (beat_idx == LAST_BEAT);
                beat_idx      <= beat_idx + ADDR_W'(1);
            end else if (m_axis_tvalid && m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            if (last_acc) begin
                busy      <= 1'b0;
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_bram_frame_reader.sv
// Self-checking bench for bram_frame_reader: default 40-halfword instance
// plus an 8-halfword instance at BRAM base 0x100, sharing one BRAM image.
module tb_bram_frame_reader;
    import bram_frame_reader_pkg::*;

    localparam int NHW = FRAME_HW_DEFAULT;
    localparam int NB  = NHW / 2;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        frame_irq = 1'b0;
    logic        m_axis_tready = 1'b0;
    logic [11:0] bram_addr;
    logic        bram_en;
    logic [15:0] bram_dout;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        busy;
    logic [15:0] frame_cnt;
    logic [15:0] drop_cnt;

    logic        irq_s = 1'b0;
    logic        tready_s = 1'b1;
    logic [11:0] addr_s;
    logic        en_s;
    logic [15:0] dout_s;
    logic [31:0] tdata_s;
    logic        tvalid_s;
    logic        tlast_s;
    logic        busy_s;
    logic [15:0] fcnt_s;
    logic [15:0] dcnt_s;

    logic [15:0] mem [0:4095];

    always #5 aclk = ~aclk;

    always @(posedge aclk) begin
        if (bram_en) bram_dout <= mem[bram_addr];
        if (en_s) dout_s <= mem[addr_s];
    end

    bram_frame_reader u_dut (
        .aclk          (aclk),
        .areset        (areset),
        .frame_irq     (frame_irq),
        .bram_addr     (bram_addr),
        .bram_en       (bram_en),
        .bram_dout     (bram_dout),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .drop_cnt      (drop_cnt)
    );

    bram_frame_reader #(
        .FRAME_HW  (8),
        .BASE_ADDR (12'h100),
        .ADDR_W    (12)
    ) u_small (
        .aclk          (aclk),
        .areset        (areset),
        .frame_irq     (irq_s),
        .bram_addr     (addr_s),
        .bram_en       (en_s),
        .bram_dout     (dout_s),
        .m_axis_tdata  (tdata_s),
        .m_axis_tvalid (tvalid_s),
        .m_axis_tready (tready_s),
        .m_axis_tlast  (tlast_s),
        .busy          (busy_s),
        .frame_cnt     (fcnt_s),
        .drop_cnt      (dcnt_s)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int edge_no = 0;
    int trig_edge = 0;
    int exp_frames = 0;
    int exp_drops = 0;

    logic [31:0] bd [$];
    bit          bl [$];
    int          reads_n;
    int          acc_n;
    int          fv_edge;
    int          last_edge;
    bit          prev_stall;
    logic [31:0] prev_data;
    logic        prev_last;
    logic [11:0] sa [$];
    logic [31:0] sd [$];
    bit          sl [$];

    typedef struct {
        int          pct;
        int          max_ticks;
        bit          timing;
        int          exp_beats;
        logic [31:0] exp_first;
        logic [31:0] exp_final;
    } vec_t;

    vec_t tbl [3];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_le(input string name, input int act, input int lim);
        n_cmp++;
        if (act > lim) begin
            n_bad++;
            $display("FAIL %s: got %0d required <= %0d", name, act, lim);
        end
    endtask

    task automatic clr_mon();
        bd.delete();
        bl.delete();
        sa.delete();
        sd.delete();
        sl.delete();
        reads_n = 0;
        acc_n = 0;
        fv_edge = -1;
        last_edge = -1;
        prev_stall = 0;
        prev_data = '0;
        prev_last = 1'b0;
    endtask

    // One clock: observe at the falling edge, then return 1 time unit after
    // the rising edge so the caller can change inputs.
    task automatic tick();
        @(negedge aclk);
        if (m_axis_tvalid === 1'b1 && fv_edge < 0) fv_edge = edge_no;
        if (prev_stall) begin
            check("stall_valid", 32'(m_axis_tvalid), 32'd1);
            check("stall_data", m_axis_tdata, prev_data);
            check("stall_last", 32'(m_axis_tlast), 32'(prev_last));
        end
        if (bram_en === 1'b1) begin
            reads_n++;
            check_le("occupancy", reads_n - 2 * acc_n, 6);
        end
        if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
            bd.push_back(m_axis_tdata);
            bl.push_back(m_axis_tlast);
            acc_n++;
            if (m_axis_tlast) last_edge = edge_no;
        end
        prev_stall = (m_axis_tvalid === 1'b1) && !m_axis_tready;
        prev_data = m_axis_tdata;
        prev_last = m_axis_tlast;
        if (en_s === 1'b1) sa.push_back(addr_s);
        if (tvalid_s === 1'b1 && tready_s) begin
            sd.push_back(tdata_s);
            sl.push_back(tlast_s);
        end
        @(posedge aclk);
        edge_no++;
        #1;
    endtask

    task automatic wait_idle(input int nbeats, input int max_ticks,
                             input int pct);
        for (int i = 0; i < max_ticks; i++) begin
            m_axis_tready = (int'($urandom_range(99, 0)) < pct);
            tick();
            if (bd.size() >= nbeats && !busy) break;
        end
        m_axis_tready = 1'b1;
        repeat (4) tick();
    endtask

    task automatic pulse_irq();
        frame_irq = 1'b1;
        trig_edge = edge_no + 1;
        tick();
        frame_irq = 1'b0;
    endtask

    task automatic check_frames(input string tag, input int nf);
        logic [15:0] k;
        logic [31:0] exp;
        check({tag, "_beats"}, 32'(bd.size()), 32'(nf * NB));
        for (int i = 0; i < bd.size(); i++) begin
            k = 16'h1000 + 16'(2 * (i % NB));
            exp = {k, k + 16'd1};
            check({tag, "_data"}, bd[i], exp);
            check({tag, "_last"}, 32'(bl[i]), 32'((i % NB) == NB - 1));
        end
    endtask

    initial begin
        for (int k = 0; k < 4096; k++) mem[k] = 16'h1000 + 16'(k);

        tbl[0] = '{100, 200, 1'b1, NB, 32'h10001001, 32'h10261027};
        tbl[1] = '{30, 800, 1'b0, NB, 32'h10001001, 32'h10261027};
        tbl[2] = '{70, 400, 1'b0, NB, 32'h10001001, 32'h10261027};

        areset = 1'b1;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_bram_en", 32'(bram_en), 32'd0);
        check("rst_bram_addr", 32'(bram_addr), 32'd0);
        check("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check("rst_tdata", m_axis_tdata, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        areset = 1'b0;
        m_axis_tready = 1'b1;
        clr_mon();
        tick();
        tick();

        for (int r = 0; r < 3; r++) begin
            clr_mon();
            m_axis_tready = 1'b1;
            pulse_irq();
            wait_idle(tbl[r].exp_beats, tbl[r].max_ticks, tbl[r].pct);
            check_frames("tbl", 1);
            check("tbl_first", bd.size() > 0 ? bd[0] : 32'h0, tbl[r].exp_first);
            check("tbl_final", bd.size() > 0 ? bd[bd.size() - 1] : 32'h0,
                  tbl[r].exp_final);
            exp_frames++;
            check("tbl_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
            check("tbl_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
            check("tbl_busy", 32'(busy), 32'd0);
            if (tbl[r].timing) begin
                check("first_valid_lat", 32'(fv_edge - trig_edge), 32'd4);
                check_le("tlast_lat", last_edge - trig_edge, 43);
            end
        end

        // irq stretched for 256 cycles, second edge 100 cycles after the end
        clr_mon();
        m_axis_tready = 1'b1;
        frame_irq = 1'b1;
        repeat (256) tick();
        frame_irq = 1'b0;
        repeat (100) tick();
        pulse_irq();
        wait_idle(2 * NB, 300, 100);
        check_frames("hold", 2);
        exp_frames += 2;
        check("hold_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check("hold_drop_cnt", 32'(drop_cnt), 32'(exp_drops));

        // second edge while stalled at beat 5
        clr_mon();
        m_axis_tready = 1'b1;
        pulse_irq();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_n >= 5) break;
        end
        m_axis_tready = 1'b0;
        tick();
        frame_irq = 1'b1;
        tick();
        frame_irq = 1'b0;
        repeat (3) tick();
        exp_drops++;
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        check("drop_busy", 32'(busy), 32'd1);
        wait_idle(NB, 200, 100);
        repeat (60) tick();
        check_frames("drop", 1);
        exp_frames++;
        check("drop_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // reset in the middle of a frame
        clr_mon();
        m_axis_tready = 1'b1;
        pulse_irq();
        for (int i = 0; i < 100; i++) begin
            tick();
            if (acc_n >= 10) break;
        end
        areset = 1'b1;
        tick();
        check("mid_rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_bram_en", 32'(bram_en), 32'd0);
        check("mid_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("mid_rst_drop_cnt", 32'(drop_cnt), 32'd0);
        areset = 1'b0;
        exp_frames = 0;
        exp_drops = 0;
        tick();
        clr_mon();
        pulse_irq();
        wait_idle(NB, 200, 100);
        check_frames("post_rst", 1);
        exp_frames++;
        check("post_rst_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // 8-halfword instance at base 0x100
        clr_mon();
        irq_s = 1'b1;
        tick();
        irq_s = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (sd.size() >= 4 && !busy_s) break;
        end
        repeat (4) tick();
        check("small_reads", 32'(sa.size()), 32'd8);
        for (int i = 0; i < sa.size(); i++) begin
            check("small_addr", 32'(sa[i]), 32'h100 + 32'(i));
        end
        check("small_beats", 32'(sd.size()), 32'd4);
        for (int i = 0; i < sd.size(); i++) begin
            check("small_data", sd[i],
                  {16'h1100 + 16'(2 * i), 16'h1101 + 16'(2 * i)});
            check("small_last", 32'(sl[i]), 32'(i == 3));
        end
        check("small_frame_cnt", 32'(fcnt_s), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
